// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : multicycle MIPS controller types, opcodes and ALU codes.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mips_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      BNEEX   = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11,
      JEX     = 4'd12
   } statetype;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALUCTL_AND = 3'b000;
   localparam logic [2:0] ALUCTL_OR  = 3'b001;
   localparam logic [2:0] ALUCTL_ADD = 3'b010;
   localparam logic [2:0] ALUCTL_SUB = 3'b110;
   localparam logic [2:0] ALUCTL_SLT = 3'b111;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       branchn;
      logic       irwrite;
      logic       regwrite;
      logic       memwrite;
      logic       alusrca;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      aluop_t     aluop;
   } ctrl_t;

   // Moore output table: everything not named for a state stays zero (aluop zero = add).
   function automatic ctrl_t state_ctrl(input statetype s);
      ctrl_t c;
      c       = '0;
      c.aluop = ALUOP_ADD;
      case (s)
         FETCH: begin
            c.alusrcb = 2'b01;
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
         end
         DECODE: begin
            c.alusrcb = 2'b11;
         end
         MEMADR, ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         MEMRD: begin
            c.iord = 1'b1;
         end
         MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         ADDIWB: begin
            c.regwrite = 1'b1;
         end
         RTYPEEX: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         BEQEX: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_SUB;
            c.pcsrc   = 2'b01;
            c.branch  = 1'b1;
         end
         BNEEX: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_SUB;
            c.pcsrc   = 2'b01;
            c.branchn = 1'b1;
         end
         JEX: begin
            c.pcsrc   = 2'b10;
            c.pcwrite = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aludec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aludec : combinational ALU control decode from aluop and funct.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module aludec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   input  aluop_t     aluop,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALUCTL_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALUCTL_ADD;
         ALUOP_SUB: alucontrol = ALUCTL_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: alucontrol = ALUCTL_ADD;
               FUNCT_SUB: alucontrol = ALUCTL_SUB;
               FUNCT_AND: alucontrol = ALUCTL_AND;
               FUNCT_OR:  alucontrol = ALUCTL_OR;
               FUNCT_SLT: alucontrol = ALUCTL_SLT;
               default:   alucontrol = ALUCTL_ADD;
            endcase
         end
         default: alucontrol = ALUCTL_ADD;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | controller : multicycle MIPS main FSM with ALU decode sub-block.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module controller
   import mips_pkg::*;
#(
   parameter int SUPPORT_BNE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal
);

   statetype r_state;
   statetype w_next_state;
   ctrl_t    r_ctrl;
   logic     w_op_known;

   always_comb begin
      w_op_known = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_op_known = 1'b1;
         OP_BNE:  w_op_known = (SUPPORT_BNE != 0);
         default: w_op_known = 1'b0;
      endcase
   end

   always_comb begin
      w_next_state = FETCH;
      case (r_state)
         FETCH: w_next_state = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next_state = MEMADR;
               OP_RTYPE:     w_next_state = RTYPEEX;
               OP_BEQ:       w_next_state = BEQEX;
               OP_BNE:       w_next_state = (SUPPORT_BNE != 0) ? BNEEX : FETCH;
               OP_ADDI:      w_next_state = ADDIEX;
               OP_J:         w_next_state = JEX;
               default:      w_next_state = FETCH;
            endcase
         end
         MEMADR:  w_next_state = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   w_next_state = MEMWB;
         RTYPEEX: w_next_state = RTYPEWB;
         ADDIEX:  w_next_state = ADDIWB;
         default: w_next_state = FETCH;
      endcase
   end

   // Outputs are registered alongside the state so they decode the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FETCH;
         r_ctrl  <= state_ctrl(FETCH);
      end else begin
         r_state <= w_next_state;
         r_ctrl  <= state_ctrl(w_next_state);
      end
   end

   // Write strobes are masked by reset so an aborted instruction cannot write anything.
   assign pcen     = reset & (r_ctrl.pcwrite | (r_ctrl.branch & zero) | (r_ctrl.branchn & ~zero));
   assign irwrite  = reset & r_ctrl.irwrite;
   assign regwrite = reset & r_ctrl.regwrite;
   assign memwrite = reset & r_ctrl.memwrite;
   assign alusrca  = r_ctrl.alusrca;
   assign iord     = r_ctrl.iord;
   assign memtoreg = r_ctrl.memtoreg;
   assign regdst   = r_ctrl.regdst;
   assign alusrcb  = r_ctrl.alusrcb;
   assign pcsrc    = r_ctrl.pcsrc;
   assign illegal  = (r_state == DECODE) & ~w_op_known;

   aludec u_aludec (
      .funct      (funct),
      .aluop      (r_ctrl.aluop),
      .alucontrol (alucontrol)
   );

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_controller : vector table, reset corner cases and random program. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_controller;
   import mips_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       illegal;

   int n_cmp  = 0;
   int n_fail = 0;

   controller #(.SUPPORT_BNE(1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
      .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
      logic [1:0] alusrcb, pcsrc;
      logic [2:0] alucontrol;
      logic       chk_alu;
      logic       illegal;
   } obs_t;

   obs_t cap [1:5];

   // Instruction length in cycles, straight from the per-class cycle counts.
   function automatic int instr_len(input logic [5:0] o);
      case (o)
         6'b100011:                      return 5;
         6'b101011, 6'b000000, 6'b001000: return 4;
         6'b000100, 6'b000101, 6'b000010: return 3;
         default:                        return 2;
      endcase
   endfunction

   function automatic logic [2:0] funct_map(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected outputs for cycle number cyc (1-based) of an instruction.
   function automatic obs_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int cyc);
      obs_t e;
      e = '{default: '0};
      if (cyc == 1) begin
         e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; e.alucontrol = 3'b010; e.chk_alu = 1;
      end else if (cyc == 2) begin
         e.alusrcb = 2'b11; e.alucontrol = 3'b010; e.chk_alu = 1;
         e.illegal = (instr_len(o) == 2);
      end else begin
         case (o)
            6'b100011, 6'b101011, 6'b001000: begin
               if (cyc == 3) begin
                  e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; e.chk_alu = 1;
               end else if (o == 6'b101011) begin
                  e.iord = 1; e.memwrite = 1;
               end else if (o == 6'b001000) begin
                  e.regwrite = 1;
               end else if (cyc == 4) begin
                  e.iord = 1;
               end else begin
                  e.regwrite = 1; e.memtoreg = 1;
               end
            end
            6'b000000: begin
               if (cyc == 3) begin
                  e.alusrca = 1; e.alucontrol = funct_map(f); e.chk_alu = 1;
               end else begin
                  e.regdst = 1; e.regwrite = 1;
               end
            end
            6'b000100, 6'b000101: begin
               e.alusrca = 1; e.pcsrc = 2'b01; e.alucontrol = 3'b110; e.chk_alu = 1;
               e.pcen = (o == 6'b000100) ? z : ~z;
            end
            6'b000010: begin
               e.pcsrc = 2'b10; e.pcen = 1;
            end
            default: ;
         endcase
      end
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t s;
      s.pcen = pcen; s.irwrite = irwrite; s.regwrite = regwrite; s.memwrite = memwrite;
      s.alusrca = alusrca; s.iord = iord; s.memtoreg = memtoreg; s.regdst = regdst;
      s.alusrcb = alusrcb; s.pcsrc = pcsrc; s.alucontrol = alucontrol;
      s.chk_alu = 1'b1; s.illegal = illegal;
      return s;
   endfunction

   function automatic string fmt(input obs_t s);
      return $sformatf("pcen=%b ir=%b rw=%b mw=%b asa=%b iord=%b m2r=%b rd=%b asb=%b pcs=%b aluc=%b ill=%b",
                       s.pcen, s.irwrite, s.regwrite, s.memwrite, s.alusrca, s.iord,
                       s.memtoreg, s.regdst, s.alusrcb, s.pcsrc, s.alucontrol, s.illegal);
   endfunction

   task automatic check_obs(input string name, input obs_t got, input obs_t exp);
      logic bad;
      bad = (got.pcen !== exp.pcen) || (got.irwrite !== exp.irwrite) ||
            (got.regwrite !== exp.regwrite) || (got.memwrite !== exp.memwrite) ||
            (got.alusrca !== exp.alusrca) || (got.iord !== exp.iord) ||
            (got.memtoreg !== exp.memtoreg) || (got.regdst !== exp.regdst) ||
            (got.alusrcb !== exp.alusrcb) || (got.pcsrc !== exp.pcsrc) ||
            (got.illegal !== exp.illegal) ||
            (exp.chk_alu && (got.alucontrol !== exp.alucontrol));
      n_cmp++;
      if (bad) begin
         n_fail++;
         $display("FAIL %s got {%s} want {%s}", name, fmt(got), fmt(exp));
      end
   endtask

   task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h want %0h", name, got, exp);
      end
   endtask

   // Entered just after a falling edge with the DUT in FETCH; leaves the same way.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
      op = o; funct = f; zero = z;
      for (int c = 1; c <= instr_len(o); c++) begin
         #1;
         cap[c] = sample();
         check_obs($sformatf("op%b_f%b_z%b_c%0d", o, f, z, c), cap[c], model(o, f, z, c));
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [5:0] op, funct;
      logic       zero;
      int         ecyc;
      logic       e_pcen;
      logic [1:0] e_pcsrc;
      logic       e_reg, e_mem, e_ill;
      logic       e_aluchk;
      logic [2:0] e_aluc;
   } vec_t;

   vec_t vecs [$];

   initial begin
      logic [5:0] ops [8];
      logic [5:0] fns [5];
      obs_t       g;

      vecs = '{
         '{6'b100011, 6'b000000, 1'b0, 5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000},
         '{6'b101011, 6'b000000, 1'b0, 4, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000},
         '{6'b000000, 6'b101010, 1'b0, 3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111},
         '{6'b000000, 6'b101010, 1'b1, 4, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000},
         '{6'b000000, 6'b111111, 1'b0, 3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010},
         '{6'b000000, 6'b100000, 1'b0, 3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010},
         '{6'b000000, 6'b100010, 1'b0, 3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110},
         '{6'b000000, 6'b100100, 1'b0, 3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000},
         '{6'b000000, 6'b100101, 1'b0, 3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001},
         '{6'b000100, 6'b000000, 1'b1, 3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110},
         '{6'b000100, 6'b000000, 1'b0, 3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110},
         '{6'b000101, 6'b000000, 1'b0, 3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110},
         '{6'b000101, 6'b000000, 1'b1, 3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110},
         '{6'b001000, 6'b000000, 1'b0, 3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010},
         '{6'b001000, 6'b000000, 1'b0, 4, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000},
         '{6'b000010, 6'b000000, 1'b0, 3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000},
         '{6'b111111, 6'b000000, 1'b0, 2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010}
      };

      reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_val("rst_strobes", {4'b0, pcen, irwrite, regwrite, memwrite}, 8'h00);
      check_val("rst_state", {7'b0, dut.r_state == FETCH}, 8'h01);
      @(posedge clk); #1;
      check_val("rst_strobes_edge", {4'b0, pcen, irwrite, regwrite, memwrite}, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      // Directed vector table.
      foreach (vecs[i]) begin
         run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero);
         g = cap[vecs[i].ecyc];
         check_val($sformatf("vec%0d_pcen", i), {7'b0, g.pcen}, {7'b0, vecs[i].e_pcen});
         check_val($sformatf("vec%0d_pcsrc", i), {6'b0, g.pcsrc}, {6'b0, vecs[i].e_pcsrc});
         check_val($sformatf("vec%0d_wr", i), {6'b0, g.regwrite, g.memwrite},
                   {6'b0, vecs[i].e_reg, vecs[i].e_mem});
         check_val($sformatf("vec%0d_ill", i), {7'b0, g.illegal}, {7'b0, vecs[i].e_ill});
         if (vecs[i].e_aluchk)
            check_val($sformatf("vec%0d_aluc", i), {5'b0, g.alucontrol}, {5'b0, vecs[i].e_aluc});
      end

      // Reset asserted mid-cycle in MEMWB of a lw.
      op = 6'b100011; funct = '0; zero = 1'b0;
      for (int c = 1; c < 5; c++) @(negedge clk);
      #1;
      check_val("midrst_pre_rw", {7'b0, regwrite}, 8'h01);
      reset = 1'b0;
      #1;
      check_val("midrst_strobes", {4'b0, pcen, irwrite, regwrite, memwrite}, 8'h00);
      check_val("midrst_state", {7'b0, dut.r_state == FETCH}, 8'h01);
      @(posedge clk); #1;
      check_val("midrst_hold", {4'b0, pcen, irwrite, regwrite, memwrite}, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("midrst_release_fetch", {6'b0, irwrite, pcen}, 8'h03);
      @(negedge clk);
      check_val("midrst_decode", {6'b0, irwrite, pcen}, 8'h00);
      @(negedge clk);  // lw DECODE -> MEMADR; let it finish, then sync to FETCH
      for (int c = 3; c <= 5; c++) @(negedge clk);

      // Random instruction stream against the model.
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b000000};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      for (int n = 0; n < 160; n++) begin
         logic [5:0] ro, rf;
         logic       rz;
         int         sel;
         sel = $urandom_range(0, 8);
         ro  = (sel == 8) ? 6'($urandom) : ops[sel];
         rf  = ($urandom_range(0, 1) == 1) ? fns[$urandom_range(0, 4)] : 6'($urandom);
         rz  = 1'($urandom);
         run_instr(ro, rf, rz);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout compared=%0d mismatched=%0d", n_cmp, n_fail);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have parameter SUPPORT_BNE, default 1, which enables decoding of bne (op 000101).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 SHALL have port op  input  6  instr[31:26] from datapath.
REQ-005 SHALL have port funct  input  6  instr[5:0] from datapath.
REQ-006 SHALL have port zero  input  1  ALU zero flag, combinational from datapath.
REQ-007 SHALL have outputs pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst, each 1 bit: datapath and memory strobes/selects.
REQ-008 SHALL have outputs alusrcb and pcsrc, each 2 bits, and alucontrol, 3 bits.
REQ-009 SHALL have output illegal  output  1  high for one cycle in DECODE when op is unsupported.

Function
REQ-010 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, ADDIEX, ADDIWB, JEX; the only Mealy term is pcen.
REQ-011 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR for lw 100011 and sw 101011; RTYPEEX for 000000; BEQEX for 000100; BNEEX for 000101 when SUPPORT_BNE=1; ADDIEX for 001000; JEX for 000010; any other op->FETCH.
REQ-012 Further transitions SHALL be: MEMADR->MEMRD for lw, MEMWR for sw; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; and MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX each ->FETCH.
REQ-013 Cycle counts SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne/j 3, illegal 2.
REQ-014 FETCH outputs SHALL be: iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, irwrite=1, pcwrite=1.
REQ-015 DECODE outputs SHALL be alusrca=0, alusrcb=11, aluop=add, which precomputes the branch target into aluout.
REQ-016 MEMADR and ADDIEX outputs SHALL be alusrca=1, alusrcb=10, aluop=add.
REQ-017 MEMRD outputs SHALL be iord=1; MEMWR outputs SHALL be iord=1, memwrite=1.
REQ-018 MEMWB outputs SHALL be regdst=0, memtoreg=1, regwrite=1.
REQ-019 ADDIWB outputs SHALL be regdst=0, memtoreg=0, regwrite=1.
REQ-020 RTYPEEX outputs SHALL be alusrca=1, alusrcb=00, aluop=funct; RTYPEWB outputs SHALL be regdst=1, memtoreg=0, regwrite=1.
REQ-021 BEQEX and BNEEX outputs SHALL be alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, with branch asserted in BEQEX and branchn asserted in BNEEX.
REQ-022 JEX outputs SHALL be pcsrc=10, pcwrite=1.
REQ-023 pcen SHALL equal pcwrite | (branch & zero) | (branchn & ~zero).
REQ-024 Every output not listed for a state SHALL be 0, with no X values.
REQ-025 ALU decode SHALL map aluop=add->010 and aluop=sub->110.
REQ-026 For aluop=funct, decode SHALL map 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, and any other funct->010.
REQ-027 At most one of regwrite, memwrite, irwrite SHALL be high in any cycle.

Reset
REQ-028 reset low SHALL force state to FETCH immediately and asynchronously.
REQ-029 While reset is low, pcen, irwrite, regwrite and memwrite SHALL be forced to 0 combinationally.
REQ-030 The first rising edge after reset deassertion SHALL perform the FETCH writes; reset asserted in any state SHALL abort the instruction with no register or memory write.

Structure
REQ-031 A shared package mips_pkg SHALL hold the state enum (statetype), the opcode localparams (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J), the aluop enum, the funct codes, and the alucontrol codes.
REQ-032 The block SHALL contain one sub-module, aludec (funct, aluop -> alucontrol), which is combinational; the FSM with its next-state and output logic stays in controller.

Verification
REQ-033 Scenario lw: op=100011 after reset -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; pcen=1 only in cycle 1.
REQ-034 Scenario sw: op=101011 -> memwrite=1 and iord=1 exactly in cycle 4, regwrite=0 throughout, back to FETCH in cycle 5.
REQ-035 Scenario R-type: op=000000, funct=101010 -> alucontrol=111 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB; funct=111111 -> alucontrol=010.
REQ-036 Scenario branch: beq with zero=1 -> pcen=1 and pcsrc=01 in BEQEX; beq with zero=0 -> pcen=0; bne with zero=0 -> pcen=1.
REQ-037 Scenario jump/illegal: op=000010 -> pcsrc=10 and pcen=1 in JEX; op=111111 -> illegal=1 in DECODE, then FETCH with no writes.
REQ-038 Scenario reset mid-op: reset driven low mid-cycle while in MEMWB -> regwrite drops before the next edge and the state reads FETCH.
